twiddle_fetch_arb: RTL and testbench

- Shares the single-port 512-entry cosine ROM (10-bit data, 1-cycle registered read) among N_REQ FFT butterfly/stage requesters.
- Each accepted request carries a twiddle index k; the block performs two sequential ROM reads:
  - cos address k,
  - sin address (k + SIN_OFS) mod 2^A_WIDTH, using quarter-wave symmetry.
- Returns cos and (optionally negated) sin, tagged with the requester id.
- Sits between the butterfly stage controllers and the ROM; the ROM instance itself stays outside this block.

---
 rtl/twiddle_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 30 +++
 rtl/twiddle_fetch_arb.sv | 114 +++++++++++
 tb/tb_twiddle_fetch_arb.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/twiddle_pkg.sv
// Shared widths, FSM encoding and the saturating negate used by the twiddle fetch path.
package twiddle_pkg;

  localparam int A_WIDTH_DEF = 9;
  localparam int D_WIDTH_DEF = 10;
  localparam int SIN_OFS_DEF = 384;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_COS = 2'd1,
    RD_SIN = 2'd2,
    CAPT   = 2'd3
  } state_t;

  // x is a w-bit two's complement value sign-extended to 32 bits; the most negative
  // value has no positive twin, so it clamps to the largest positive one.
  function automatic logic [31:0] sat_neg(input logic [31:0] x, input int w);
    logic [31:0] min_v;
    min_v = 32'hFFFF_FFFF << (w - 1);
    if (x == min_v) return ~min_v;
    return 32'd0 - x;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority one-hot arbiter: ptr has top priority, then ptr+1, wrapping at N.
// Purely combinational, zero latency; grant is all-zero when en is low or nothing requests.
module rr_arbiter #(
  parameter int  N  = 4,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic          en,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  logic [PW-1:0] pos;
  logic          found;

  // N is a power of two, so pos wraps naturally.
  always_comb begin
    grant = '0;
    found = 1'b0;
    pos   = '0;
    for (int i = 0; i < N; i++) begin
      pos = ptr + PW'(i);
      if (en && !found && req[pos]) begin
        grant[pos] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/twiddle_fetch_arb.sv
// Arbitrates N_REQ requesters onto one cos ROM, reading cos then sin for each index; rsp 4 cycles after accept.
// One request per 4 cycles; req_ready is low outside IDLE, responses have no backpressure.
module twiddle_fetch_arb
  import twiddle_pkg::*;
#(
  parameter int  N_REQ   = 4,
  parameter int  A_WIDTH = A_WIDTH_DEF,
  parameter int  D_WIDTH = D_WIDTH_DEF,
  parameter int  SIN_OFS = SIN_OFS_DEF,
  parameter int  NEG_SIN = 1,
  localparam int ID_W    = $clog2(N_REQ)
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*A_WIDTH-1:0] req_idx,
  output logic [N_REQ-1:0]         req_ready,
  output logic [A_WIDTH-1:0]       rom_addr,
  input  logic [D_WIDTH-1:0]       rom_data,
  output logic                     rsp_valid,
  output logic [ID_W-1:0]          rsp_id,
  output logic [D_WIDTH-1:0]       rsp_cos,
  output logic [D_WIDTH-1:0]       rsp_sin,
  output logic                     busy
);

  state_t             state;
  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    id_q;
  logic [A_WIDTH-1:0] idx_q;
  logic [D_WIDTH-1:0] cos_q;

  logic [N_REQ-1:0]   grant;
  logic [ID_W-1:0]    win_id;
  logic [A_WIDTH-1:0] sel_idx;
  logic [D_WIDTH-1:0] sin_val;

  rr_arbiter #(
    .N (N_REQ)
  ) u_arb (
    .req   (req_valid),
    .en    (state == IDLE),
    .ptr   (ptr),
    .grant (grant)
  );

  assign req_ready = grant;

  always_comb begin
    win_id = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) win_id = ID_W'(i);
    end
  end

  assign sel_idx = req_idx[int'(win_id) * A_WIDTH +: A_WIDTH];

  always_comb begin
    sin_val = rom_data;
    if (NEG_SIN != 0) sin_val = D_WIDTH'(sat_neg(32'(signed'(rom_data)), D_WIDTH));
  end

  // ROM read is registered: the address set in one state returns data two states later.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      ptr       <= '0;
      id_q      <= '0;
      idx_q     <= '0;
      cos_q     <= '0;
      rom_addr  <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_cos   <= '0;
      rsp_sin   <= '0;
      busy      <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (|grant) begin
            id_q     <= win_id;
            idx_q    <= sel_idx;
            rom_addr <= sel_idx;
            ptr      <= win_id + ID_W'(1);
            busy     <= 1'b1;
            state    <= RD_COS;
          end
        end
        RD_COS: begin
          rom_addr <= idx_q + A_WIDTH'(SIN_OFS);
          state    <= RD_SIN;
        end
        RD_SIN: begin
          cos_q <= rom_data;
          state <= CAPT;
        end
        CAPT: begin
          rsp_cos   <= cos_q;
          rsp_sin   <= sin_val;
          rsp_id    <= id_q;
          rsp_valid <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_twiddle_fetch_arb.sv
// Directed and random requests against a queue/arithmetic reference of the arbitration and ROM-read rules.
module tb_twiddle_fetch_arb;

  localparam int N   = 4;
  localparam int AW  = 9;
  localparam int DW  = 10;
  localparam int OFS = 384;

  logic            clk = 1'b0;
  logic            rstn;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_idx;
  logic [N-1:0]    req_ready, req_ready_p;
  logic [AW-1:0]   rom_addr, rom_addr_p;
  logic [DW-1:0]   rom_data, rom_data_p;
  logic            rsp_valid, rsp_valid_p;
  logic [1:0]      rsp_id, rsp_id_p;
  logic [DW-1:0]   rsp_cos, rsp_cos_p, rsp_sin, rsp_sin_p;
  logic            busy, busy_p;

  twiddle_fetch_arb #(.N_REQ(N), .A_WIDTH(AW), .D_WIDTH(DW), .SIN_OFS(OFS), .NEG_SIN(1)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_idx(req_idx), .req_ready(req_ready),
    .rom_addr(rom_addr), .rom_data(rom_data), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_cos(rsp_cos), .rsp_sin(rsp_sin), .busy(busy)
  );

  twiddle_fetch_arb #(.N_REQ(N), .A_WIDTH(AW), .D_WIDTH(DW), .SIN_OFS(OFS), .NEG_SIN(0)) dut_p (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_idx(req_idx), .req_ready(req_ready_p),
    .rom_addr(rom_addr_p), .rom_data(rom_data_p), .rsp_valid(rsp_valid_p), .rsp_id(rsp_id_p),
    .rsp_cos(rsp_cos_p), .rsp_sin(rsp_sin_p), .busy(busy_p)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] rom [0:511];
  always @(posedge clk) begin
    rom_data   <= rom[rom_addr];
    rom_data_p <= rom[rom_addr_p];
  end

  int n_chk, n_pass, cyc;
  int rem [N];
  int idx_v [N];
  int mptr, free_at, g_cyc, e_id, e_idx;
  bit pend;
  logic [DW-1:0] e_cos, e_sin_r, e_sin_n;
  logic [1:0]    l_id;
  logic [DW-1:0] l_cos, l_sin, l_sin_p;
  int grant_log [$];

  function automatic logic [DW-1:0] neg_ref(input logic [DW-1:0] v);
    int s, r;
    s = v[DW-1] ? int'(v) - (1 << DW) : int'(v);
    r = (s == -(1 << (DW - 1))) ? (1 << (DW - 1)) - 1 : -s;
    return DW'(r);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic bit any_rem();
    for (int i = 0; i < N; i++) if (rem[i] > 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int log_at(input int i);
    return (grant_log.size() > i) ? grant_log[i] : -1;
  endfunction

  // Runs the outstanding rem[] requests to completion, checking every cycle against the model.
  task automatic run(input int budget);
    int n, w;
    logic [N-1:0] eg;
    n = 0;
    while ((any_rem() || pend) && n < budget) begin
      for (int i = 0; i < N; i++) begin
        if (rem[i] == 0) idx_v[i] = $urandom_range(0, 511);
        req_valid[i] = (rem[i] > 0);
        req_idx[i*AW +: AW] = AW'(idx_v[i]);
      end
      #1;
      eg = '0;
      w  = -1;
      if (cyc >= free_at)
        for (int k = 0; k < N; k++)
          if (w < 0 && rem[(mptr + k) % N] > 0) w = (mptr + k) % N;
      if (w >= 0) eg[w] = 1'b1;
      check("req_ready", 32'(req_ready), 32'(eg));
      check("req_ready_pos", 32'(req_ready_p), 32'(eg));
      check("busy", 32'(busy), 32'(pend && cyc < g_cyc + 4));
      check("busy_pos", 32'(busy_p), 32'(pend && cyc < g_cyc + 4));
      if (pend && cyc == g_cyc + 1) check("rom_addr_cos", 32'(rom_addr), e_idx);
      if (pend && cyc == g_cyc + 2) check("rom_addr_sin", 32'(rom_addr), (e_idx + OFS) % 512);
      if (pend && cyc == g_cyc + 4) begin
        check("rsp_valid", 32'(rsp_valid), 32'h1);
        check("rsp_valid_pos", 32'(rsp_valid_p), 32'h1);
        check("rsp_id", 32'(rsp_id), e_id);
        check("rsp_cos", 32'(rsp_cos), 32'(e_cos));
        check("rsp_sin_neg", 32'(rsp_sin), 32'(e_sin_n));
        check("rsp_sin_pos", 32'(rsp_sin_p), 32'(e_sin_r));
        l_id    = 2'(e_id);
        l_cos   = e_cos;
        l_sin   = e_sin_n;
        l_sin_p = e_sin_r;
        pend    = 1'b0;
      end else begin
        check("rsp_valid_idle", 32'(rsp_valid), 32'h0);
        check("rsp_valid_idle_pos", 32'(rsp_valid_p), 32'h0);
        check("rsp_id_hold", 32'(rsp_id), 32'(l_id));
        check("rsp_cos_hold", 32'(rsp_cos), 32'(l_cos));
        check("rsp_sin_hold", 32'(rsp_sin), 32'(l_sin));
        check("rsp_sin_hold_pos", 32'(rsp_sin_p), 32'(l_sin_p));
      end
      if (w >= 0) begin
        pend    = 1'b1;
        g_cyc   = cyc;
        free_at = cyc + 4;
        e_id    = w;
        e_idx   = idx_v[w];
        e_cos   = rom[e_idx];
        e_sin_r = rom[(e_idx + OFS) % 512];
        e_sin_n = neg_ref(e_sin_r);
        mptr    = (w + 1) % N;
        rem[w]--;
        grant_log.push_back(w);
        if (rem[w] > 0) idx_v[w] = $urandom_range(0, 511);
      end
      tick();
      n++;
    end
    check("run_budget", 32'(n < budget), 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_pass = 0; cyc = 0;
    mptr = 0; free_at = 0; g_cyc = 0; pend = 1'b0;
    e_id = 0; e_idx = 0; e_cos = '0; e_sin_r = '0; e_sin_n = '0;
    l_id = '0; l_cos = '0; l_sin = '0; l_sin_p = '0;
    rstn = 1'b0; req_valid = '0; req_idx = '0;
    for (int i = 0; i < N; i++) begin rem[i] = 0; idx_v[i] = 0; end
    for (int a = 0; a < 512; a++) rom[a] = DW'(a + 768);

    repeat (3) @(posedge clk);
    #1;
    check("reset_rom_addr", 32'(rom_addr), 32'h0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    check("reset_rsp_id", 32'(rsp_id), 32'h0);
    check("reset_rsp_cos", 32'(rsp_cos), 32'h0);
    check("reset_rsp_sin", 32'(rsp_sin), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_ready", 32'(req_ready), 32'h0);
    rstn = 1'b1;
    tick();

    // Sin address wraps: 200 + 384 - 512 = 72.
    rem[0] = 1; idx_v[0] = 200;
    run(40);
    check("wrap_rom_addr", 32'(rom_addr), 32'd72);
    check("wrap_cos", 32'(rsp_cos), 32'h3C8);
    check("wrap_sin", 32'(rsp_sin), 32'h0B8);

    rem[1] = 1; idx_v[1] = 0;
    run(40);
    check("t1_id", 32'(rsp_id), 32'h1);
    check("t1_cos", 32'(rsp_cos), 32'h300);
    check("t1_sin", 32'(rsp_sin), 32'h380);
    check("t1_sin_pos", 32'(rsp_sin_p), 32'h080);

    grant_log.delete();
    rem[2] = 2; idx_v[2] = $urandom_range(0, 511);
    run(40);
    check("b2b_grants", grant_log.size(), 32'd2);

    rom[384] = 10'h200;
    rem[3] = 1; idx_v[3] = 0;
    run(40);
    check("sat_sin_neg", 32'(rsp_sin), 32'h1FF);
    check("sat_sin_pos", 32'(rsp_sin_p), 32'h200);
    rom[384] = DW'(384 + 768);

    grant_log.delete();
    for (int i = 0; i < N; i++) begin rem[i] = 1; idx_v[i] = $urandom_range(0, 511); end
    run(60);
    for (int i = 0; i < N; i++) check("rr_order", log_at(i), i);
    grant_log.delete();
    for (int i = 0; i < N; i++) begin rem[i] = 1; idx_v[i] = $urandom_range(0, 511); end
    run(60);
    check("rr_return0", log_at(0), 32'd0);

    // Reset while in RD_SIN after granting requester 1 (pointer would then be 2).
    req_valid = 4'b0010;
    req_idx[1*AW +: AW] = 9'd5;
    #1;
    check("mr_grant", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    check("mr_busy", 32'(busy), 32'h1);
    tick();
    rstn = 1'b0;
    #1;
    check("mr_rom_addr", 32'(rom_addr), 32'h0);
    check("mr_rsp_valid", 32'(rsp_valid), 32'h0);
    check("mr_rsp_id", 32'(rsp_id), 32'h0);
    check("mr_rsp_cos", 32'(rsp_cos), 32'h0);
    check("mr_rsp_sin", 32'(rsp_sin), 32'h0);
    check("mr_rsp_sin_pos", 32'(rsp_sin_p), 32'h0);
    check("mr_busy_low", 32'(busy), 32'h0);
    tick();
    check("mr_no_rsp", 32'(rsp_valid), 32'h0);
    rstn = 1'b1;
    mptr = 0; pend = 1'b0; free_at = cyc;
    l_id = '0; l_cos = '0; l_sin = '0; l_sin_p = '0;
    grant_log.delete();
    rem[1] = 1; rem[3] = 1;
    idx_v[1] = $urandom_range(0, 511); idx_v[3] = $urandom_range(0, 511);
    run(40);
    check("mr_ptr_reset", log_at(0), 32'd1);

    for (int a = 0; a < 512; a++) rom[a] = DW'($urandom);
    for (int k = 0; k < 8; k++) rom[$urandom_range(0, 511)] = 10'h200;
    for (int it = 0; it < 20; it++) begin
      for (int i = 0; i < N; i++) begin
        rem[i]   = $urandom_range(0, 2);
        idx_v[i] = $urandom_range(0, 511);
      end
      if (!any_rem()) rem[it % N] = 1;
      run(200);
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
